// File: rtl/apb_master_arb.sv
// apb_master_arb: round-robin arbiter that shares one APB master port among
// NUM_REQ local requesters and sequences each accepted request through the
// APB SETUP/ACCESS phases, returning read data to the winning requester.
//
// Optional build feature: define APB_ARB_TIMEOUT_EN to bound the ACCESS phase
// to TIMEOUT_CYCLES cycles. A timed-out transfer completes with rsp_err=1 and
// rsp_rdata=0. Without the macro, ACCESS waits for PREADY forever and rsp_err
// is tied low.
//
// Handshake semantics (requester side): a request transfers on a rising PCLK
// edge where req_valid[i] & req_ready[i] are both 1. req_ready is asserted
// combinationally, one-hot, only at a grant point (IDLE, or ACCESS with
// PREADY=1), and only to the round-robin winner. A requester holds req_valid
// and its payload stable until it sees req_ready. rsp_valid[i] is a one-cycle
// pulse with no back-pressure; rsp_rdata/rsp_err are meaningful only with it.

module apb_master_arb #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic                          PWRITE,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  output logic [1:0]                    state_dbg
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CND_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   owner;

  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [CND_W-1:0]   cand;

  logic               grant_pt;
  logic               grant_hs;
  logic               complete;
  logic               timeout_hit;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_write;

  // Round-robin search: first valid requester starting after last_grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + CND_W'(k) + CND_W'(1);
      if (cand >= CND_W'(NUM_REQ)) begin
        cand = cand - CND_W'(NUM_REQ);
      end
      if (!gnt_found && req_valid[cand[IDX_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Payload of the current round-robin winner.
  always_comb begin
    sel_addr  = req_addr[ADDR_WIDTH*gnt_idx +: ADDR_WIDTH];
    sel_wdata = req_wdata[DATA_WIDTH*gnt_idx +: DATA_WIDTH];
    sel_write = req_write[gnt_idx];
  end

  // Grant point: idle, or the completing ACCESS cycle (back-to-back transfers).
  always_comb begin
    complete  = (state == ACCESS) && PREADY;
    grant_pt  = (state == IDLE) || complete;
    grant_hs  = grant_pt && gnt_found;
    req_ready = '0;
    if (grant_hs) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_hs) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          state_nxt = gnt_found ? SETUP : IDLE;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM outputs: APB phase strobes decoded from the registered state.
  always_comb begin
    PSEL      = (state == SETUP) || (state == ACCESS);
    PENABLE   = (state == ACCESS);
    state_dbg = state;
  end

  // Transfer latch: capture the winner's payload on the handshake edge.
  // PADDR/PWDATA keep their last value when idle; PSEL alone marks validity.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR      <= '0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      owner      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (grant_hs) begin
      PADDR      <= sel_addr;
      PWRITE     <= sel_write;
      PWDATA     <= sel_wdata;
      owner      <= gnt_idx;
      last_grant <= gnt_idx;
    end
  end

  // Completion pulse to the owner; read data is returned only for reads.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      if (complete) begin
        rsp_valid[owner] <= 1'b1;
        rsp_rdata        <= PWRITE ? '0 : PRDATA;
      end else if (timeout_hit) begin
        rsp_valid[owner] <= 1'b1;
        rsp_rdata        <= '0;
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;

  // Count ACCESS cycles; the count restarts from zero on every ACCESS entry.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      to_cnt <= '0;
    end else if (state == ACCESS) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  // The last allowed ACCESS cycle without PREADY forces completion.
  assign timeout_hit = (state == ACCESS) && !PREADY &&
                       (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Error flag accompanies the forced-completion pulse only.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= timeout_hit;
    end
  end
`else
  // TIMEOUT_CYCLES is a positive count, so this never fires: ACCESS waits
  // for PREADY indefinitely in this build.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: directed bench for apb_master_arb with two requesters
// and a small APB slave model (programmable wait states, PRDATA = base ^ PADDR).
// Build with +define+APB_ARB_TIMEOUT_EN to include the ACCESS timeout case.

module tb_apb_master_arb;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic PCLK = 1'b0;
  logic PRESETn;
  always #5 PCLK = ~PCLK;

  // ---------------- DUT signals ----------------
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_write;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic [AW-1:0]    PADDR;
  logic             PWRITE;
  logic             PSEL;
  logic             PENABLE;
  logic [DW-1:0]    PWDATA;
  logic [DW-1:0]    PRDATA;
  logic             PREADY;
  logic [1:0]       state_dbg;

  logic [AW-1:0] addr_a  [NR];
  logic [DW-1:0] wdata_a [NR];
  assign req_addr  = {addr_a[1], addr_a[0]};
  assign req_wdata = {wdata_a[1], wdata_a[0]};

  apb_master_arb #(
    .NUM_REQ        (NR),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .state_dbg (state_dbg)
  );

  // ---------------- APB slave model ----------------
  logic [DW-1:0] slave_base;
  int            wait_states;
  logic          slave_hang;
  int            acc_cnt;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) acc_cnt <= 0;
    else if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  assign PREADY = !slave_hang && (acc_cnt >= wait_states);
  assign PRDATA = slave_base ^ PADDR;

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  int            exp_gnt_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Runs a stream of n grants with the current req_valid pattern held; each
  // granted requester advances its address by 4. Expected grant order and
  // read data come from exp_gnt_q / exp_q.
  task automatic run_stream(input int n, output int psel_cyc, output int pen_cyc,
                            output int idle_cyc);
    int grants;
    int resps;
    int gidx;
    int o;
    int own_q[$];
    logic [63:0] one;
    one      = 64'd1;
    grants   = 0;
    resps    = 0;
    psel_cyc = 0;
    pen_cyc  = 0;
    idle_cyc = 0;
    own_q    = exp_gnt_q;
    for (int c = 0; c < 60 && resps < n; c++) begin
      if (rsp_valid != '0) begin
        if (own_q.size() > 0) begin
          o = own_q.pop_front();
          check("rsp_owner", 64'(rsp_valid), one << o);
          check("rsp_rdata", 64'(rsp_rdata), 64'(exp_q.pop_front()));
          check("rsp_err", 64'(rsp_err), 64'd0);
        end else begin
          check("rsp_extra", 64'(rsp_valid), 64'd0);
        end
        resps++;
      end
      if (grants > 0 && resps < n) begin
        psel_cyc += int'(PSEL);
        pen_cyc  += int'(PENABLE);
        idle_cyc += int'(state_dbg == 2'd0);
      end
      gidx = -1;
      if (req_ready != '0) begin
        check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
        gidx = req_ready[1] ? 1 : 0;
        if (exp_gnt_q.size() > 0) check("grant", 64'(gidx), 64'(exp_gnt_q.pop_front()));
        else check("grant_extra", 64'(gidx), 64'hFFFF);
        grants++;
      end
      tick();
      if (gidx >= 0) begin
        addr_a[gidx] = addr_a[gidx] + 32'd4;
        if (grants >= n) req_valid = '0;
      end
      settle();
    end
    check("stream_done", 64'(resps), 64'(n));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int acc;
    int nrsp;
    int psel_cyc;
    int pen_cyc;
    int idle_cyc;

    PRESETn     = 1'b0;
    req_valid   = '0;
    req_write   = '0;
    addr_a[0]   = '0;
    addr_a[1]   = '0;
    wdata_a[0]  = '0;
    wdata_a[1]  = '0;
    slave_base  = '0;
    wait_states = 0;
    slave_hang  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_psel", 64'(PSEL), 64'd0);
    check("rst_penable", 64'(PENABLE), 64'd0);
    check("rst_pwrite", 64'(PWRITE), 64'd0);
    check("rst_paddr", 64'(PADDR), 64'd0);
    check("rst_pwdata", 64'(PWDATA), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    PRESETn = 1'b1;
    tick();

    // Test 1: single write from req0, zero-wait slave
    addr_a[0]  = 32'h10;
    wdata_a[0] = 32'hDEADBEEF;
    req_write  = 2'b01;
    req_valid  = 2'b01;
    settle();
    check("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    settle();
    check("t1_setup_psel", 64'(PSEL), 64'd1);
    check("t1_setup_penable", 64'(PENABLE), 64'd0);
    check("t1_paddr", 64'(PADDR), 64'h10);
    check("t1_pwdata", 64'(PWDATA), 64'hDEADBEEF);
    check("t1_pwrite", 64'(PWRITE), 64'd1);
    check("t1_ready_off", 64'(req_ready), 64'd0);
    tick();
    check("t1_access_psel", 64'(PSEL), 64'd1);
    check("t1_access_penable", 64'(PENABLE), 64'd1);
    check("t1_rsp_early", 64'(rsp_valid), 64'd0);
    tick();
    check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t1_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("t1_rsp_err", 64'(rsp_err), 64'd0);
    check("t1_idle_psel", 64'(PSEL), 64'd0);
    tick();
    check("t1_rsp_pulse", 64'(rsp_valid), 64'd0);
    check("t1_paddr_hold", 64'(PADDR), 64'h10);

    // Test 2: read from req1 with 3 wait states
    slave_base  = 32'h12345658;  // ^ 0x20 gives 0x12345678
    wait_states = 3;
    addr_a[1]   = 32'h20;
    req_write   = 2'b00;
    req_valid   = 2'b10;
    settle();
    check("t2_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    settle();
    check("t2_psel", 64'(PSEL), 64'd1);
    check("t2_paddr", 64'(PADDR), 64'h20);
    check("t2_pwrite", 64'(PWRITE), 64'd0);
    acc  = 0;
    nrsp = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      acc += int'(PSEL && PENABLE);
      if (rsp_valid != '0) begin
        nrsp++;
        check("t2_rsp_valid", 64'(rsp_valid), 64'h2);
        check("t2_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
      end
    end
    check("t2_access_cycles", 64'(acc), 64'd4);
    check("t2_rsp_count", 64'(nrsp), 64'd1);

    // Test 3: both requesters held valid for 6 reads, alternating grants
    slave_base  = 32'hA5A50000;
    wait_states = 0;
    addr_a[0]   = 32'h100;
    addr_a[1]   = 32'h200;
    req_write   = 2'b00;
    exp_gnt_q   = '{0, 1, 0, 1, 0, 1};
    exp_q       = '{32'hA5A50100, 32'hA5A50200, 32'hA5A50104,
                    32'hA5A50204, 32'hA5A50108, 32'hA5A50208};
    req_valid   = 2'b11;
    settle();
    run_stream(6, psel_cyc, pen_cyc, idle_cyc);
    check("t3_psel_cycles", 64'(psel_cyc), 64'd12);
    check("t3_penable_cycles", 64'(pen_cyc), 64'd6);
    check("t3_idle_gaps", 64'(idle_cyc), 64'd0);
    check("t3_end_psel", 64'(PSEL), 64'd0);

    // Test 4: back-to-back reads from req0 only
    addr_a[0] = 32'h40;
    exp_gnt_q = '{0, 0, 0};
    exp_q     = '{32'hA5A50040, 32'hA5A50044, 32'hA5A50048};
    req_valid = 2'b01;
    settle();
    run_stream(3, psel_cyc, pen_cyc, idle_cyc);
    check("t4_psel_cycles", 64'(psel_cyc), 64'd6);
    check("t4_penable_cycles", 64'(pen_cyc), 64'd3);
    check("t4_idle_gaps", 64'(idle_cyc), 64'd0);

    // Test 5: asynchronous reset during ACCESS
    wait_states = 5;
    addr_a[1]   = 32'h60;
    req_valid   = 2'b10;
    settle();
    check("t5_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    tick();
    check("t5_in_access", 64'(PENABLE), 64'd1);
    #2 PRESETn = 1'b0;
    #1;
    check("t5_async_psel", 64'(PSEL), 64'd0);
    check("t5_async_penable", 64'(PENABLE), 64'd0);
    check("t5_async_state", 64'(state_dbg), 64'd0);
    nrsp = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      nrsp += int'(rsp_valid != '0);
    end
    PRESETn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      nrsp += int'(rsp_valid != '0);
    end
    check("t5_no_rsp", 64'(nrsp), 64'd0);
    wait_states = 0;
    addr_a[0]   = 32'h70;
    req_valid   = 2'b11;
    settle();
    check("t5_req0_first", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    tick();
    tick();
    check("t5_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t5_rsp_rdata", 64'(rsp_rdata), 64'hA5A50070);

`ifdef APB_ARB_TIMEOUT_EN
    // Test 6: ACCESS timeout after 4 cycles, then a normal transfer
    tick();
    slave_hang = 1'b1;
    addr_a[0]  = 32'h80;
    wdata_a[0] = 32'h55;
    req_write  = 2'b01;
    req_valid  = 2'b01;
    settle();
    check("t6_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    acc  = 0;
    nrsp = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      acc += int'(PSEL && PENABLE);
      if (rsp_valid != '0) begin
        nrsp++;
        check("t6_rsp_valid", 64'(rsp_valid), 64'h1);
        check("t6_rsp_err", 64'(rsp_err), 64'd1);
        check("t6_rsp_rdata", 64'(rsp_rdata), 64'd0);
      end
    end
    check("t6_access_cycles", 64'(acc), 64'd4);
    check("t6_rsp_count", 64'(nrsp), 64'd1);
    check("t6_psel_off", 64'(PSEL), 64'd0);
    slave_hang = 1'b0;
    addr_a[1]  = 32'h90;
    req_write  = 2'b00;
    req_valid  = 2'b10;
    settle();
    check("t6_next_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    tick();
    tick();
    check("t6_next_rsp_valid", 64'(rsp_valid), 64'h2);
    check("t6_next_rsp_err", 64'(rsp_err), 64'd0);
    check("t6_next_rsp_rdata", 64'(rsp_rdata), 64'hA5A50090);
`endif

    // Final report
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
